uart_mike_tx: RTL and testbench

UART transmitter that serializes one byte per request into a start/data/parity/stop frame on a single output line. It is the transmit-side counterpart of the receive path and uses the shared UART package frame layout and FSM encoding. It sits between a byte-producing host (register interface or FIFO) and the UART pin. Completion is reported through a sticky done flag that the host must clear explicitly before the next byte is accepted.

---
 rtl/uart_mike_tx_pkg.sv | 36 +++
 rtl/uart_mike_tx_if.sv | 14 +
 rtl/uart_mike_tx_baud_cnt.sv | 25 ++
 rtl/uart_mike_tx.sv | 91 +++++++++
 tb/tb_uart_mike_tx.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/uart_mike_tx_pkg.sv
// Shared UART package: FSM encoding, frame layout and frame-building helper.
// Used by the transmitter; parity framing is selected by UART_MIKE_PARITY_EN.
package UART_MIKE_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    RX_DATA      = 2'd1,
    TX_DATA      = 2'd2,
    WAIT_FLG_CLR = 2'd3
  } UART_FSM;

  localparam int unsigned UART_DATA_WIDTH        = 8;
  localparam int unsigned UART_FRAME_WIDHT       = 11;
  localparam int unsigned UART_FRAME_NOPAR_WIDTH = 10;
  localparam int unsigned UART_FRAME_SIZE        = $clog2(UART_FRAME_WIDHT);

  // Packed LSB-first: start leaves the shift register first, stop last.
  typedef struct packed {
    logic                       stop;
    logic                       parity;
    logic [UART_DATA_WIDTH-1:0] tx_byte;
    logic                       start;
  } tx_byte_stop;

  // Without parity the parity slot carries a 1, so it is sent as the stop bit.
  function automatic tx_byte_stop make_frame(input logic [UART_DATA_WIDTH-1:0] data,
                                             input logic par_en, input logic odd);
    tx_byte_stop f;
    f.start   = 1'b0;
    f.tx_byte = data;
    f.parity  = par_en ? ((^data) ^ odd) : 1'b1;
    f.stop    = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/uart_mike_tx_if.sv
// Host-side handshake bundle for uart_mike_tx (request, data, flag clear, line and status).
interface uart_mike_tx_if
  import UART_MIKE_pkg::*;
;
  logic                       tx_start;
  logic [UART_DATA_WIDTH-1:0] tx_data;
  logic                       tx_flg_clr;
  logic                       tx;
  logic                       tx_busy;
  logic                       tx_done;

  modport master (output tx_start, tx_data, tx_flg_clr, input  tx, tx_busy, tx_done);
  modport slave  (input  tx_start, tx_data, tx_flg_clr, output tx, tx_busy, tx_done);
endinterface

// File: rtl/uart_mike_tx_baud_cnt.sv
// Bit-period counter: counts while enabled, pulses bit_tick on its terminal count.
module uart_mike_baud_cnt #(
  parameter int unsigned BIT_CLKS = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic bit_tick
);
  localparam int unsigned   CW   = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_CLKS - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  always_comb begin
    bit_tick = en && (cnt_q == LAST);
    if (!en || bit_tick) cnt_d = '0;
    else                 cnt_d = cnt_q + 1'b1;
  end
endmodule

// File: rtl/uart_mike_tx.sv
// UART transmitter: one byte per request, sticky done flag cleared by the host.
// Define UART_MIKE_PARITY_EN for an 11-bit frame with parity; default is 10-bit, no parity.
module uart_mike_tx
  import UART_MIKE_pkg::*;
#(
  parameter int unsigned BIT_CLKS   = 10,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic           clk,
  input  logic           rst,
  uart_mike_tx_if.slave  bus
);
`ifdef UART_MIKE_PARITY_EN
  localparam logic        PAR_EN     = 1'b1;
  localparam int unsigned FRAME_BITS = UART_FRAME_WIDHT;
`else
  localparam logic        PAR_EN     = 1'b0;
  localparam int unsigned FRAME_BITS = UART_FRAME_NOPAR_WIDTH;
`endif
  localparam int unsigned                W        = UART_FRAME_WIDHT;
  localparam logic [UART_FRAME_SIZE-1:0] IDX_LAST = UART_FRAME_SIZE'(FRAME_BITS - 1);

  UART_FSM                      state_q, state_d;
  logic [W-1:0]                 shift_q, shift_d;
  logic [UART_FRAME_SIZE-1:0]   idx_q, idx_d;
  logic                         done_q, done_d;
  logic                         bit_tick;
  logic                         last_tick;

  uart_mike_baud_cnt #(.BIT_CLKS(BIT_CLKS)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .en       (state_q == TX_DATA),
    .bit_tick (bit_tick)
  );

  assign last_tick = bit_tick && (idx_q == IDX_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '1;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:         if (bus.tx_start)   state_d = TX_DATA;
      TX_DATA:      if (last_tick)      state_d = WAIT_FLG_CLR;
      WAIT_FLG_CLR: if (bus.tx_flg_clr) state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    done_d  = done_q;
    case (state_q)
      IDLE: if (bus.tx_start) begin
        shift_d = make_frame(bus.tx_data, PAR_EN, PARITY_ODD != 0);
        idx_d   = '0;
      end
      TX_DATA: if (bit_tick) begin
        shift_d = {1'b1, shift_q[W-1:1]};
        if (last_tick) begin
          idx_d  = '0;
          done_d = 1'b1;
        end else begin
          idx_d  = idx_q + 1'b1;
        end
      end
      WAIT_FLG_CLR: if (bus.tx_flg_clr) done_d = 1'b0;
      default: ;
    endcase
  end

  always_comb begin
    bus.tx      = (state_q == TX_DATA) ? shift_q[0] : 1'b1;
    bus.tx_busy = (state_q == TX_DATA) || (state_q == WAIT_FLG_CLR);
    bus.tx_done = done_q;
  end
endmodule

// File: tb/tb_uart_mike_tx.sv
// Bench for uart_mike_tx: two instances (10 clk/bit even parity, 2 clk/bit odd parity).
module tb_uart_mike_tx;
`ifdef UART_MIKE_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int BC_A = 10;
  localparam int BC_B = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_mike_tx_if bus_a ();
  uart_mike_tx_if bus_b ();

  uart_mike_tx #(.BIT_CLKS(BC_A), .PARITY_ODD(0)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  uart_mike_tx #(.BIT_CLKS(BC_B), .PARITY_ODD(1)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int   n_checks;
  int   n_fail;
  logic exp_q[$];

  typedef struct {
    int         sel;
    logic [7:0] data;
    logic       par;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic get_tx(input int sel);
    return sel != 0 ? bus_b.tx : bus_a.tx;
  endfunction
  function automatic logic get_busy(input int sel);
    return sel != 0 ? bus_b.tx_busy : bus_a.tx_busy;
  endfunction
  function automatic logic get_done(input int sel);
    return sel != 0 ? bus_b.tx_done : bus_a.tx_done;
  endfunction

  task automatic set_in(input int sel, input logic st, input logic [7:0] d, input logic clr);
    if (sel != 0) begin
      bus_b.tx_start = st; bus_b.tx_data = d; bus_b.tx_flg_clr = clr;
    end else begin
      bus_a.tx_start = st; bus_a.tx_data = d; bus_a.tx_flg_clr = clr;
    end
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] d, input logic par);
`ifdef UART_MIKE_PARITY_EN
    return {1'b1, par, d, 1'b0};
`else
    return {1'b1, 1'b1, d, 1'b0};
`endif
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called #1 after an edge with the selected DUT idle.
  task automatic send_frame(input int sel, input logic [7:0] d, input logic [10:0] bits,
                            input bit glitch, input int abort_at, input bit combo);
    int bc;
    bc = (sel != 0) ? BC_B : BC_A;
    set_in(sel, 1'b1, d, 1'b0);
    for (int i = 0; i < NB; i++) exp_q.push_back(bits[i]);
    tick;
    set_in(sel, 1'b0, ~d, 1'b0);
    for (int k = 0; k < NB * bc; k++) begin
      chk("line_bit", 32'(get_tx(sel)), 32'(exp_q[0]));
      if (k % bc == 0) begin
        chk("busy_in_frame", 32'(get_busy(sel)), 32'd1);
        chk("done_in_frame", 32'(get_done(sel)), 32'd0);
      end
      if (k % bc == bc - 1) void'(exp_q.pop_front());
      if (k == abort_at) begin
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("abort_tx",   32'(get_tx(sel)),   32'd1);
        chk("abort_busy", 32'(get_busy(sel)), 32'd0);
        chk("abort_done", 32'(get_done(sel)), 32'd0);
        exp_q.delete();
        for (int j = 0; j < 130; j++) begin
          tick;
          if (get_done(sel) !== 1'b0 || get_tx(sel) !== 1'b1) begin
            chk("abort_quiet", {get_done(sel), get_tx(sel)}, 32'b01);
            break;
          end
        end
        return;
      end
      if (glitch && (k == 30 || k == 105)) set_in(sel, 1'b1, 8'h3C, 1'b1);
      else                                  set_in(sel, 1'b0, ~d, 1'b0);
      tick;
    end
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("done_rise",  32'(get_done(sel)), 32'd1);
    chk("tx_after",   32'(get_tx(sel)),   32'd1);
    chk("busy_wait",  32'(get_busy(sel)), 32'd1);
    repeat (3) tick;
    chk("done_sticky", 32'(get_done(sel)), 32'd1);
    set_in(sel, combo, 8'h99, 1'b1);
    tick;
    set_in(sel, 1'b0, 8'h00, 1'b0);
    chk("done_clear", 32'(get_done(sel)), 32'd0);
    chk("busy_clear", 32'(get_busy(sel)), 32'd0);
    if (combo) begin
      for (int j = 0; j < 25; j++) begin
        tick;
        if (get_tx(sel) !== 1'b1 || get_busy(sel) !== 1'b0) begin
          chk("combo_no_frame", {get_busy(sel), get_tx(sel)}, 32'b01);
          break;
        end
      end
      chk("combo_idle_busy", 32'(get_busy(sel)), 32'd0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    set_in(0, 1'b0, 8'h00, 1'b0);
    set_in(1, 1'b0, 8'h00, 1'b0);

    tbl[0] = '{0, 8'hA5, 1'b0};
    tbl[1] = '{0, 8'h00, 1'b0};
    tbl[2] = '{0, 8'hFF, 1'b0};
    tbl[3] = '{0, 8'h80, 1'b1};
    tbl[4] = '{1, 8'h01, 1'b0};
    tbl[5] = '{1, 8'h00, 1'b1};
    tbl[6] = '{1, 8'h37, 1'b0};

    tick;
    for (int i = 0; i < 20; i++) begin
      chk("rst_tx_a",   32'(bus_a.tx),      32'd1);
      chk("rst_busy_a", 32'(bus_a.tx_busy), 32'd0);
      chk("rst_done_a", 32'(bus_a.tx_done), 32'd0);
      chk("rst_tx_b",   32'(bus_b.tx),      32'd1);
      tick;
    end
    rst = 1'b0;
    set_in(0, 1'b0, 8'h00, 1'b1);
    tick;
    set_in(0, 1'b0, 8'h00, 1'b0);
    chk("idle_clr_done", 32'(bus_a.tx_done), 32'd0);
    chk("idle_clr_busy", 32'(bus_a.tx_busy), 32'd0);
    repeat (3) tick;

    for (int i = 0; i < 7; i++)
      send_frame(tbl[i].sel, tbl[i].data, frame_of(tbl[i].data, tbl[i].par), 1'b0, -1, 1'b0);

    send_frame(0, 8'h5A, frame_of(8'h5A, 1'b0), 1'b1, -1, 1'b1);
    tick;
    send_frame(0, 8'hC3, frame_of(8'hC3, 1'b0), 1'b0, 45, 1'b0);
    tick;
    send_frame(0, 8'h6E, frame_of(8'h6E, 1'b1), 1'b0, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
